i2c_target: RTL and testbench
=============================

# i2c_target

I2C target (responder) with a byte-wide register file, addressed by an I2C controller over SCL/SDA. It is oversampled in the system clock domain and sits on the far side of the bus from the team's I2C controller, for loopback benches and for emulating peripherals such as the Nunchuck. Bus writes land in the register file and are echoed on a strobe port. Bus reads return register contents. A host port gives fabric-side read/write access to the same registers.

## Interface

**Parameters**
- `DEV_ADDR`, default `7'h52`: 7-bit target address.
- `NUM_REGS`, default `8`: register count. Must be a power of 2, at least 2. `PW = $clog2(NUM_REGS)`.

**Ports**
- `clk`  in  1: system clock. Frequency at least 16× SCL.
- `rst`  in  1: reset, synchronous, active-high.
- `scl`  in  1: bus clock pin (input only; no clock stretching).
- `sda_in`  in  1: SDA pin value.
- `sda_oe`  out  1: drive SDA low when 1, release when 0 (open-drain).
- `host_addr`  in  PW: host register index.
- `host_we`  in  1: host write enable.
- `host_wdata`  in  8: host write data.
- `host_rdata`  out  8: `regs[host_addr]`, registered, 1-cycle latency.
- `wr_strobe`  out  1: one-cycle pulse per bus-written data byte.
- `wr_addr`  out  PW: register index of the last bus write.
- `wr_data`  out  8: data of the last bus write.
- `busy`  out  1: high from START until STOP.

## Operation

**Input conditioning and bus events**
- `scl` and `sda_in` each pass through a 2-flop synchronizer. Edge detection uses the synchronized copies.
- START: synchronized SDA falls while SCL is high. Valid in any state, including repeated START. Action: go to ADDR, clear the bit counter, set `busy`.
- STOP: SDA rises while SCL is high. Action: go to IDLE, `sda_oe`=0, `busy`=0.

**Data movement**
- Sampling: SDA is shifted in MSB-first on each SCL rising edge.
- Driving: `sda_oe` changes only on SCL falling edges (apart from reset and STOP).

**States**
- IDLE: wait for START.
- ADDR: shift in 8 bits, {addr[6:0], rw}.
  - addr == `DEV_ADDR`: go to ADDR_ACK.
  - Otherwise: go to WAIT without acknowledging.
- ADDR_ACK: drive low for one SCL bit.
  - rw=0: go to PTR.
  - rw=1: load `shreg = regs[ptr]`, go to RDATA.
- PTR: shift in 8 bits. `ptr <= byte[PW-1:0]` (upper bits ignored). Go to PTR_ACK, then WDATA.
- WDATA: shift in 8 bits.
  - `regs[ptr] <= byte`.
  - Pulse `wr_strobe` with `wr_addr = ptr`, `wr_data = byte`.
  - Go to WDATA_ACK (ACK), then WDATA. Pointer increment is per Configuration.
- RDATA: drive `shreg` MSB-first. `sda_oe = ~bit`.
- RACK: release SDA and sample the controller's ACK bit.
  - 0 (ACK): advance pointer, reload `shreg`, go to RDATA.
  - 1 (NACK): go to WAIT.
- WAIT: SDA released. Ignore everything until START or STOP.

**Host port and collisions**
- A host write updates `regs[host_addr]`.
- A bus write and a host write to the same index in the same cycle: the bus write wins.
- Pointer arithmetic wraps modulo NUM_REGS.

## Timing

**Reset values**
- On `rst`: all outputs 0, `regs` all 0, `ptr`=0, state IDLE, synchronizers cleared.
- Reset mid-transfer releases SDA in the next cycle. The target then ignores the bus until a fresh START.

**Latency**
- Pin edge to synchronized edge: 2 clk. Edge detection adds 1 clk. Total: 3 clk.
- Bit capture: occurs in the cycle after the synchronized SCL-rise detection.
- `sda_oe` update: 1 clk after the synchronized SCL-fall detection, i.e. 4 clk after the pin falls.
- `wr_strobe`: asserted the cycle after the 8th data bit is captured. `wr_addr` and `wr_data` are valid in that cycle and hold until the next strobe.
- ACK drive: asserted from the SCL fall after bit 8 until the next SCL fall.

**Boundary conditions**
- START or STOP mid-byte: abort the byte, no strobe, no register change.
- Read pointer reload happens at the ACK-sample edge, so the next byte reflects any host write that completed before it.

## Configuration

- `I2C_TARGET_AUTOINC_EN` defined: `ptr` increments (mod NUM_REGS) after every bus-written byte and every ACKed read byte.
- Undefined: `ptr` stays fixed after PTR. All data bytes in a transaction access the same register.

## Test plan

- Write: START, 0xA4, 0x02, 0x11, 0x22, STOP, with AUTOINC.
  - Required: ACK on all 4 bytes, `regs[2]`=0x11, `regs[3]`=0x22.
  - Required: two `wr_strobe` pulses, (2,0x11) then (3,0x22).
- Read: host preloads `regs[7]`=0x5A and `regs[0]`=0xC3. Bus sends 0xA4, 0x07, repeated START, 0xA5, then reads 2 bytes (ACK, then NACK), STOP.
  - Required: data 0x5A, 0xC3 (wrap to 0).
  - Required: SDA released after the NACK.
- Address mismatch: START, 0xA6, 0x01, 0xFF, STOP.
  - Required: `sda_oe` never asserted, no strobe, registers unchanged.
- Reset mid-byte: `rst` after 4 bits of a data byte.
  - Required: `sda_oe`=0 next cycle, registers 0, next full write transaction succeeds.
- Collision: host writes 0x33 to `regs[1]` in the same cycle as a bus write of 0x44 to reg 1.
  - Required: `regs[1]`=0x44.
- AUTOINC undefined: write 0x01, then 0xAA and 0xBB.
  - Required: `regs[1]`=0xBB, `regs[2]` unchanged.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a byte-wide register file; bus writes are echoed on wr_strobe, host port reads/writes the same registers.
// Latency: pin edge to action 3 clk (2-flop sync + registered edge detect); sda_oe moves 4 clk after the SCL pin falls.
// Backpressure: none, the target never stretches SCL. I2C_TARGET_AUTOINC_EN enables pointer auto-increment.
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h52,
    parameter int         NUM_REGS = 8,
    localparam int        PW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic [PW-1:0] host_addr,
    input  logic          host_we,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_WAIT
    } state_t;

    state_t state, state_nxt;

    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic [7:0]    rx, tx;
    logic [3:0]    cnt;
    logic          ack_q, byte_done;
    logic [PW-1:0] ptr, ptr_adv, tx_idx;
    logic [7:0]    regs [NUM_REGS];

    logic oe_nxt, rx_state, rx_shift, bit_cnt_en, ptr_load, bus_wr;
    logic ack_sample, tx_load, tx_shift;

    assign ptr_adv = AUTOINC ? ptr + PW'(1) : ptr;
    assign tx_idx  = (state == S_RACK) ? ptr_adv : ptr;

    // Synchronizers and registered bus-event detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1    <= 1'b0;
            scl_s2    <= 1'b0;
            scl_d     <= 1'b0;
            sda_s1    <= 1'b0;
            sda_s2    <= 1'b0;
            sda_d     <= 1'b0;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_s1    <= scl;
            scl_s2    <= scl_s1;
            scl_d     <= scl_s2;
            sda_s1    <= sda_in;
            sda_s2    <= sda_s1;
            sda_d     <= sda_s2;
            scl_rise  <= scl_s2 & ~scl_d;
            scl_fall  <= ~scl_s2 & scl_d;
            start_det <= scl_s2 & scl_d & ~sda_s2 & sda_d;
            stop_det  <= scl_s2 & scl_d & sda_s2 & ~sda_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_det) begin
            state_nxt = S_ADDR;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
        end else if (scl_fall) begin
            case (state)
                S_ADDR:      if (cnt == 4'd8) state_nxt = (rx[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT;
                S_ADDR_ACK:  state_nxt = rx[0] ? S_RDATA : S_PTR;
                S_PTR:       if (cnt == 4'd8) state_nxt = S_PTR_ACK;
                S_PTR_ACK:   state_nxt = S_WDATA;
                S_WDATA:     if (cnt == 4'd8) state_nxt = S_WDATA_ACK;
                S_WDATA_ACK: state_nxt = S_WDATA;
                S_RDATA:     if (cnt == 4'd8) state_nxt = S_RACK;
                S_RACK:      state_nxt = ack_q ? S_RDATA : S_WAIT;
                default:     state_nxt = state;
            endcase
        end
    end

    always_comb begin
        rx_state   = (state == S_ADDR) || (state == S_PTR) || (state == S_WDATA);
        rx_shift   = scl_rise && rx_state;
        bit_cnt_en = scl_rise && (rx_state || state == S_RDATA);
        ptr_load   = byte_done && state == S_PTR   && !start_det && !stop_det;
        bus_wr     = byte_done && state == S_WDATA && !start_det && !stop_det;
        ack_sample = scl_rise && state == S_RACK;
        tx_load    = scl_rise && ((state == S_ADDR_ACK && rx[0]) || (state == S_RACK && !sda_s2));
        tx_shift   = scl_fall && state == S_RDATA && cnt != 4'd8;
        oe_nxt     = sda_oe;
        if (scl_fall) begin
            case (state)
                S_ADDR:      oe_nxt = (cnt == 4'd8) && (rx[7:1] == DEV_ADDR);
                S_PTR,
                S_WDATA:     oe_nxt = (cnt == 4'd8);
                S_ADDR_ACK:  oe_nxt = rx[0] & ~tx[7];
                S_RDATA:     oe_nxt = (cnt == 4'd8) ? 1'b0 : ~tx[6];
                S_RACK:      oe_nxt = ack_q & ~tx[7];
                default:     oe_nxt = 1'b0;
            endcase
        end
        if (stop_det) oe_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx         <= '0;
            tx         <= '0;
            cnt        <= '0;
            ack_q      <= 1'b0;
            byte_done  <= 1'b0;
            ptr        <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            host_rdata <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            sda_oe    <= oe_nxt;
            byte_done <= rx_shift && cnt == 4'd7;
            if (rx_shift) rx <= {rx[6:0], sda_s2};
            if (start_det || state_nxt != state) cnt <= '0;
            else if (bit_cnt_en)                 cnt <= cnt + 4'd1;
            if (ack_sample) ack_q <= ~sda_s2;
            // Read data is fetched at the ACK-sample edge so late host writes are seen
            if (tx_load)       tx <= regs[tx_idx];
            else if (tx_shift) tx <= {tx[6:0], 1'b0};
            if (ptr_load)                                  ptr <= rx[PW-1:0];
            else if (bus_wr || (tx_load && state == S_RACK)) ptr <= ptr_adv;
            if (start_det)     busy <= 1'b1;
            else if (stop_det) busy <= 1'b0;
            wr_strobe <= bus_wr;
            if (bus_wr) begin
                wr_addr <= ptr;
                wr_data <= rx;
            end
            // Bus write is last so it wins a same-index collision with the host
            if (host_we) regs[host_addr] <= host_wdata;
            if (bus_wr)  regs[ptr]       <= rx;
            host_rdata <= regs[host_addr];
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged controller on an open-drain SDA model, host-port readback.
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int PW = 3;
`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          scl, ctrl_sda;
    logic          sda_oe;
    logic [PW-1:0] host_addr;
    logic          host_we;
    logic [7:0]    host_wdata, host_rdata;
    logic          wr_strobe, busy;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;
    wire           sda_line = ctrl_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int oe_hits = 0;
    logic [PW+7:0] strb_q[$];
    logic nak;
    logic [7:0] d0, d1, rd;

    always @(negedge clk) begin
        if (wr_strobe) strb_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_hits++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic qw(input int n = 1);
        repeat (5 * n) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1; scl = 1'b1; qw();
        ctrl_sda = 1'b0; qw();
        scl = 1'b0; qw();
    endtask

    task automatic i2c_rstart();
        ctrl_sda = 1'b1; qw();
        scl = 1'b1; qw();
        ctrl_sda = 1'b0; qw();
        scl = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0; qw();
        scl = 1'b1; qw();
        ctrl_sda = 1'b1; qw();
    endtask

    // inj pulses host_we across the two clk edges where the target commits the byte
    task automatic write_bit(input logic b, input bit inj = 1'b0);
        ctrl_sda = b; qw();
        scl = 1'b1;
        if (inj) begin
            repeat (3) @(negedge clk);
            host_we = 1'b1;
            repeat (2) @(negedge clk);
            host_we = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            qw(2);
        end
        scl = 1'b0; qw();
    endtask

    task automatic read_bit(output logic b);
        ctrl_sda = 1'b1; qw();
        scl = 1'b1; qw();
        b = sda_line; qw();
        scl = 1'b0; qw();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic n, input bit inj = 1'b0);
        for (int i = 7; i >= 0; i--) write_bit(d[i], inj && i == 0);
        read_bit(n);
    endtask

    task automatic read_byte(input logic last, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(last);
    endtask

    task automatic host_wr(input logic [PW-1:0] a, input logic [7:0] v);
        host_addr = a; host_wdata = v; host_we = 1'b1;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_rd(input logic [PW-1:0] a, output logic [7:0] v);
        host_addr = a;
        repeat (2) @(negedge clk);
        v = host_rdata;
    endtask

    initial begin
        rst = 1'b1; scl = 1'b1; ctrl_sda = 1'b1;
        host_addr = '0; host_we = 1'b0; host_wdata = '0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {sda_oe, busy, wr_strobe, wr_addr, wr_data, host_rdata}, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        strb_q.delete();

        // Write 0x11, 0x22 starting at reg 2
        i2c_start();
        chk("t1_busy", busy, 1);
        write_byte(8'hA4, nak); chk("t1_ack_addr", nak, 0);
        write_byte(8'h02, nak); chk("t1_ack_ptr", nak, 0);
        write_byte(8'h11, nak); chk("t1_ack_d0", nak, 0);
        write_byte(8'h22, nak); chk("t1_ack_d1", nak, 0);
        i2c_stop();
        qw();
        chk("t1_idle", busy, 0);
        host_rd(2, rd); chk("t1_reg2", rd, AI ? 8'h11 : 8'h22);
        host_rd(3, rd); chk("t1_reg3", rd, AI ? 8'h22 : 8'h00);
        chk("t1_nstrobe", strb_q.size(), 2);
        if (strb_q.size() == 2) begin
            chk("t1_strobe0", strb_q[0], {3'd2, 8'h11});
            chk("t1_strobe1", strb_q[1], {AI ? 3'd3 : 3'd2, 8'h22});
        end
        strb_q.delete();

        // Read two bytes from reg 7 with a repeated START
        host_wr(7, 8'h5A);
        host_wr(0, 8'hC3);
        i2c_start();
        write_byte(8'hA4, nak); chk("t2_ack_addr", nak, 0);
        write_byte(8'h07, nak); chk("t2_ack_ptr", nak, 0);
        i2c_rstart();
        write_byte(8'hA5, nak); chk("t2_ack_raddr", nak, 0);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        chk("t2_released", sda_oe, 0);
        i2c_stop();
        chk("t2_data0", d0, 8'h5A);
        chk("t2_data1", d1, AI ? 8'hC3 : 8'h5A);
        chk("t2_nstrobe", strb_q.size(), 0);

        // Foreign address is ignored entirely
        oe_hits = 0;
        i2c_start();
        write_byte(8'hA6, nak); chk("t3_nak_addr", nak, 1);
        write_byte(8'h01, nak);
        write_byte(8'hFF, nak);
        i2c_stop();
        chk("t3_oe_hits", oe_hits, 0);
        chk("t3_nstrobe", strb_q.size(), 0);
        host_rd(1, rd); chk("t3_reg1", rd, 8'h00);
        host_rd(7, rd); chk("t3_reg7", rd, 8'h5A);

        // Host writes 0x33 to reg 1 while the bus writes 0x44 there
        i2c_start();
        write_byte(8'hA4, nak);
        write_byte(8'h01, nak);
        host_addr = 1; host_wdata = 8'h33;
        write_byte(8'h44, nak, 1'b1); chk("t4_ack_d", nak, 0);
        i2c_stop();
        host_rd(1, rd); chk("t4_reg1", rd, 8'h44);
        chk("t4_nstrobe", strb_q.size(), 1);
        if (strb_q.size() == 1) chk("t4_strobe", strb_q[0], {3'd1, 8'h44});
        strb_q.delete();

        // Two data bytes to reg 1: fixed pointer vs auto-increment
        i2c_start();
        write_byte(8'hA4, nak);
        write_byte(8'h01, nak);
        write_byte(8'hAA, nak);
        write_byte(8'hBB, nak);
        i2c_stop();
        host_rd(1, rd); chk("t5_reg1", rd, AI ? 8'hAA : 8'hBB);
        host_rd(2, rd); chk("t5_reg2", rd, AI ? 8'hBB : 8'h22);
        chk("t5_nstrobe", strb_q.size(), 2);
        if (strb_q.size() == 2) chk("t5_strobe1", strb_q[1], {AI ? 3'd2 : 3'd1, 8'hBB});
        strb_q.delete();

        // Reset after 4 bits of a data byte, then a clean write
        i2c_start();
        write_byte(8'hA4, nak);
        write_byte(8'h03, nak);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_oe_after_rst", sda_oe, 0);
        chk("t6_busy_after_rst", busy, 0);
        host_rd(1, rd); chk("t6_reg1", rd, 8'h00);
        host_rd(3, rd); chk("t6_reg3", rd, 8'h00);
        host_rd(7, rd); chk("t6_reg7", rd, 8'h00);
        scl = 1'b1; ctrl_sda = 1'b1;
        qw(2);
        strb_q.delete();
        i2c_start();
        write_byte(8'hA4, nak); chk("t6_ack_addr", nak, 0);
        write_byte(8'h05, nak); chk("t6_ack_ptr", nak, 0);
        write_byte(8'h77, nak); chk("t6_ack_d", nak, 0);
        i2c_stop();
        host_rd(5, rd); chk("t6_reg5", rd, 8'h77);
        chk("t6_nstrobe", strb_q.size(), 1);
        if (strb_q.size() == 1) chk("t6_strobe", strb_q[0], {3'd5, 8'h77});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
